pc_branch_sequencer: RTL and testbench
======================================

// Module: pc_branch_sequencer
// PURPOSE
//  Multi-cycle PC sequencer for the 31-instruction MIPS core: owns the PC register, fetches over a
//  req/ack instruction-memory handshake, presents the instruction to decode, waits for execute, then
//  resolves beq/bne/j/jal/jr and writes the next PC. The branch target is PC+4 plus the 18-bit
//  sign-extended word offset {imm16,2'b00}.
// PARAMETERS
//  RESET_PC   32'h0040_0000   PC value loaded on reset (word aligned)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  fetch address (= pc while imem_req)
//  imem_ack     in   1   fetch complete; imem_rdata valid in the same cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  latched instruction for decode/execute
//  instr_valid  out  1   one-cycle pulse: instr is new
//  ex_done      in   1   execute finished; br_kind/rs_val/rt_val valid this cycle
//  br_kind      in   3   0 none, 1 beq, 2 bne, 3 j, 4 jal, 5 jr, 6-7 treated as none
//  rs_val       in   32  GPR[rs]
//  rt_val       in   32  GPR[rt]
//  stall        in   1   hold in UPDATE; pc is not written while high
//  pc           out  32  current PC
//  link_we      out  1   one-cycle pulse: write link_data to $31 (jal)
//  link_data    out  32  pc+4 of the jal
//  addr_err     out  1   one-cycle pulse: jr target had [1:0]!=0
// BEHAVIOUR
//  - Reset (async): state=FETCH, pc=RESET_PC, instr=0. imem_req, instr_valid, link_we, addr_err and
//    link_data are all 0. imem_req drops immediately even mid-handshake. First request is on the first
//    clk after rst deasserts.
//  - FSM states: FETCH, DECODE, EXEC, UPDATE.
//    FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, ->DECODE.
//    DECODE: instr_valid=1 for exactly this cycle, ->EXEC.
//    EXEC: wait for ex_done; on it, latch br_kind/rs_val/rt_val, ->UPDATE. EXEC takes >=1 cycle.
//    UPDATE: if stall, stay. Else write pc<=next_pc and ->FETCH.
//  - Minimum instruction latency is 4 cycles (ack in first FETCH cycle, ex_done in first EXEC cycle).
//  - imem_ack outside FETCH and ex_done outside EXEC are ignored.
//  - next_pc (all arithmetic mod 2^32; wraps 32'hFFFF_FFFC+4 -> 0):
//      seq = pc+4; btgt = seq + sext18({instr[15:0],2'b00})
//      beq: rs_val==rt_val ? btgt : seq       bne: rs_val!=rt_val ? btgt : seq
//      j/jal: {seq[31:28], instr[25:0], 2'b00}
//      jr: {rs_val[31:2],2'b00}; addr_err pulses in the UPDATE exit cycle if rs_val[1:0]!=0
//      none/6/7: seq
//  - jal: link_we pulses in the UPDATE exit cycle with link_data=seq (the old pc+4).
//    link_data holds its value until the next jal.
//  - stall and UPDATE: outputs pc/link_we/addr_err are unchanged while stalled. The pulses fire only on
//    the cycle UPDATE exits.
//  - pc changes only on the UPDATE exit edge or on reset.
// STRUCTURE
//  - Shared package (cpu_pkg): BR_NONE..BR_JR localparams (3-bit), RESET_PC default, FSM state encodings.
//  - One sub-module: branch_target_calc (comb). Inputs pc, instr, br_kind, rs_val, rt_val. Outputs
//    next_pc, misalign. Contains the 18-bit sign extension and the adders.
//  - Top holds the FSM, the pc/instr/latched-operand registers and the pulse generation.
// TESTING
//  1. Reset/fetch: rst pulse, ack after 2 wait cycles, br_kind=0 -> imem_addr=0x00400000, pc becomes 0x00400004,
//     instr_valid pulses once per instruction.
//  2. beq taken: pc=0x00400010, instr[15:0]=0xFFFE, rs=rt=5 -> pc=0x0040000C. Same with rt=6 -> pc=0x00400014.
//  3. bne forward max: instr[15:0]=0x7FFF, rs!=rt, pc=0x00400000 -> pc=0x00420000.
//     jal at pc=0x00400020 with instr[25:0]=0x0100010 -> pc=0x00400040, link_we pulse with link_data=0x00400024.
//  4. jr misaligned: rs_val=0x00400102 -> pc=0x00400100, addr_err one-cycle pulse. Also check wrap:
//     pc=0xFFFFFFFC, br_kind=0 -> pc=0.
//  5. Stall/ignore: hold stall 3 cycles in UPDATE -> pc is constant and there is no link_we until release.
//     Spurious imem_ack in EXEC and ex_done in FETCH -> no state change.
//  6. Reset mid-handshake: assert rst while imem_req=1 -> imem_req=0 in the same cycle, pc=RESET_PC,
//     fetch restarts cleanly after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core front end: branch kinds, reset PC and sequencer state codes.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BR_W = 3;
   localparam int unsigned ST_W = 2;

   localparam logic [BR_W-1:0] BR_NONE = 3'd0;
   localparam logic [BR_W-1:0] BR_BEQ  = 3'd1;
   localparam logic [BR_W-1:0] BR_BNE  = 3'd2;
   localparam logic [BR_W-1:0] BR_J    = 3'd3;
   localparam logic [BR_W-1:0] BR_JAL  = 3'd4;
   localparam logic [BR_W-1:0] BR_JR   = 3'd5;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;

   localparam logic [ST_W-1:0] ST_FETCH  = 2'd0;
   localparam logic [ST_W-1:0] ST_DECODE = 2'd1;
   localparam logic [ST_W-1:0] ST_EXEC   = 2'd2;
   localparam logic [ST_W-1:0] ST_UPDATE = 2'd3;

   // Word offset {imm16,2'b00} widened to a full address.
   function automatic logic [XLEN-1:0] sext18(input logic [17:0] v);
      return {{(XLEN-18){v[17]}}, v};
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC resolution for beq/bne/j/jal/jr; anything else falls through to pc+4.
module branch_target_calc
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [25:0]     instr,
   input  logic [BR_W-1:0] br_kind,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic [XLEN-1:0] next_pc,
   output logic            misalign
);

   logic [XLEN-1:0] seq;
   logic [XLEN-1:0] btgt;
   logic [XLEN-1:0] jtgt;

   always_comb begin
      seq      = pc + 32'd4;
      btgt     = seq + sext18({instr[15:0], 2'b00});
      jtgt     = {seq[31:28], instr[25:0], 2'b00};
      next_pc  = seq;
      misalign = 1'b0;
      case (br_kind)
         BR_BEQ:  if (rs_val == rt_val) next_pc = btgt;
         BR_BNE:  if (rs_val != rt_val) next_pc = btgt;
         BR_J,
         BR_JAL:  next_pc = jtgt;
         BR_JR: begin
            next_pc  = {rs_val[31:2], 2'b00};
            misalign = |rs_val[1:0];
         end
         default: next_pc = seq;
      endcase
   end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Multi-cycle PC sequencer: fetch over req/ack, hand the instruction to decode, wait for execute,
// then commit the resolved next PC (with jal link and jr alignment reporting).
module pc_branch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   input  logic            ex_done,
   input  logic [BR_W-1:0] br_kind,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic            link_we,
   output logic [XLEN-1:0] link_data,
   output logic            addr_err
);

   logic [ST_W-1:0] state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [BR_W-1:0] br_q, br_d;
   logic [XLEN-1:0] rs_q, rs_d;
   logic [XLEN-1:0] rt_q, rt_d;
   logic            req_q, req_d;
   logic            iv_q, iv_d;
   logic            link_we_q, link_we_d;
   logic [XLEN-1:0] link_data_q, link_data_d;
   logic            addr_err_q, addr_err_d;

   logic [XLEN-1:0] next_pc;
   logic            misalign;

   branch_target_calc u_btc (
      .pc       (pc_q),
      .instr    (instr_q[25:0]),
      .br_kind  (br_q),
      .rs_val   (rs_q),
      .rt_val   (rt_q),
      .next_pc  (next_pc),
      .misalign (misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         br_q        <= BR_NONE;
         rs_q        <= '0;
         rt_q        <= '0;
         req_q       <= 1'b0;
         iv_q        <= 1'b0;
         link_we_q   <= 1'b0;
         link_data_q <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         br_q        <= br_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         req_q       <= req_d;
         iv_q        <= iv_d;
         link_we_q   <= link_we_d;
         link_data_q <= link_data_d;
         addr_err_q  <= addr_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      br_d        = br_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      link_we_d   = 1'b0;
      link_data_d = link_data_q;
      addr_err_d  = 1'b0;

      case (state_q)
         // An ack only counts once the request is actually on the bus.
         ST_FETCH: begin
            if (req_q && imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (ex_done) begin
               br_d    = br_kind;
               rs_d    = rs_val;
               rt_d    = rt_val;
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (!stall) begin
               pc_d       = next_pc;
               addr_err_d = misalign;
               if (br_q == BR_JAL) begin
                  link_we_d   = 1'b1;
                  link_data_d = pc_q + 32'd4;
               end
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase

      // Registered strobes track the state being entered.
      req_d = (state_d == ST_FETCH);
      iv_d  = (state_d == ST_DECODE);
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = iv_q;
   assign pc          = pc_q;
   assign link_we     = link_we_q;
   assign link_data   = link_data_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Scoreboard bench for pc_branch_sequencer: driver pushes expected fetch/decode/commit records,
// a negedge monitor pops and compares them as the DUT presents each event.
module tb_pc_branch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        ex_done;
   logic [2:0]  br_kind;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic [31:0] pc;
   logic        link_we;
   logic [31:0] link_data;
   logic        addr_err;

   pc_branch_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .ex_done     (ex_done),
      .br_kind     (br_kind),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .stall       (stall),
      .pc          (pc),
      .link_we     (link_we),
      .link_data   (link_data),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] npc;
      logic        lw;
      logic [31:0] ld;
      logic        ae;
   } res_t;

   logic [31:0] fetchq[$];
   logic [31:0] instrq[$];
   res_t        resq[$];

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_link;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endfunction

   // Monitor: fetch handshakes, decode pulses, and the first FETCH cycle after a commit.
   logic prev_req = 1'b0;
   logic seen_iv  = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_req <= 1'b0;
         seen_iv  <= 1'b0;
      end else begin
         if (imem_req && imem_ack) begin
            if (fetchq.size() == 0) chk("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
            else chk("imem_addr", imem_addr, fetchq.pop_front());
         end
         if (instr_valid) begin
            if (instrq.size() == 0) chk("iv_unexpected", instr, 32'hFFFF_FFFF);
            else chk("instr", instr, instrq.pop_front());
         end
         if (imem_req && !prev_req && seen_iv) begin
            if (resq.size() == 0) chk("commit_unexpected", pc, 32'hFFFF_FFFF);
            else begin
               res_t r;
               r = resq.pop_front();
               chk("pc", pc, r.npc);
               chk("link_we", 32'(link_we), 32'(r.lw));
               chk("link_data", link_data, r.ld);
               chk("addr_err", 32'(addr_err), 32'(r.ae));
            end
         end
         prev_req <= imem_req;
         if (instr_valid) seen_iv <= 1'b1;
         else if (imem_req && !prev_req) seen_iv <= 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!imem_req && n < 50) begin
         step();
         n++;
      end
      ok = imem_req;
      if (!ok) chk("req_timeout", 32'(imem_req), 32'd1);
   endtask

   task automatic run_instr(input logic [31:0] word, input logic [2:0] kind,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input int ack_wait, input int ex_wait, input int stall_n,
                            input bit spur_ex, input bit spur_ack,
                            input logic [31:0] npc, input logic ae);
      bit   ok;
      res_t r;
      fetchq.push_back(exp_pc);
      instrq.push_back(word);
      if (kind == 3'd4) exp_link = exp_pc + 32'd4;
      r.npc = npc;
      r.lw  = (kind == 3'd4);
      r.ld  = exp_link;
      r.ae  = ae;
      resq.push_back(r);

      wait_req(ok);
      for (int i = 0; i < ack_wait; i++) begin
         if (spur_ex && i == 0) begin
            ex_done = 1'b1;
            br_kind = 3'd4;
            rs_val  = 32'h1234_5677;
         end
         step();
         ex_done = 1'b0;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      step();
      if (spur_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         step();
         imem_ack   = 1'b0;
         chk("spur_ack_instr", instr, word);
         chk("spur_ack_req", 32'(imem_req), 32'd0);
         chk("spur_ack_iv", 32'(instr_valid), 32'd0);
      end
      for (int i = 0; i < ex_wait; i++) step();
      ex_done = 1'b1;
      br_kind = kind;
      rs_val  = rs;
      rt_val  = rt;
      stall   = (stall_n > 0);
      step();
      ex_done = 1'b0;
      br_kind = 3'd0;
      rs_val  = 32'h0;
      rt_val  = 32'h0;
      for (int i = 0; i < stall_n; i++) begin
         chk("stall_pc", pc, exp_pc);
         chk("stall_link_we", 32'(link_we), 32'd0);
         chk("stall_req", 32'(imem_req), 32'd0);
         step();
      end
      stall  = 1'b0;
      exp_pc = npc;
   endtask

   task automatic reset_mid();
      bit ok;
      wait_req(ok);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_link_data", link_data, 32'h0);
      chk("rst_instr", instr, 32'h0);
      exp_pc   = RST_PC;
      exp_link = 32'h0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0;
      br_kind = 3'd0; rs_val = 32'h0; rt_val = 32'h0; stall = 1'b0;
      exp_pc = RST_PC; exp_link = 32'h0;
      repeat (3) step();
      chk("reset_pc", pc, RST_PC);
      chk("reset_req", 32'(imem_req), 32'd0);
      chk("reset_iv", 32'(instr_valid), 32'd0);
      chk("reset_link_we", 32'(link_we), 32'd0);
      chk("reset_addr_err", 32'(addr_err), 32'd0);
      chk("reset_link_data", link_data, 32'h0);
      chk("reset_instr", instr, 32'h0);
      rst = 1'b0;
      step();
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, RST_PC);

      //        word          kind  rs            rt     aw ew st sx sa  next pc       ae
      run_instr(32'h0000_0020, 3'd0, 32'h0,        32'h0, 2, 0, 0, 0, 0, 32'h0040_0004, 1'b0);
      run_instr(32'h03E0_0008, 3'd5, 32'h0040_0010, 32'h0, 0, 0, 0, 0, 0, 32'h0040_0010, 1'b0);
      run_instr(32'h1000_FFFE, 3'd1, 32'd5,        32'd5, 0, 1, 0, 0, 0, 32'h0040_000C, 1'b0);
      run_instr(32'h03E0_0008, 3'd5, 32'h0040_0010, 32'h0, 0, 0, 0, 0, 0, 32'h0040_0010, 1'b0);
      run_instr(32'h1000_FFFE, 3'd1, 32'd5,        32'd6, 1, 0, 0, 0, 0, 32'h0040_0014, 1'b0);
      run_instr(32'h03E0_0008, 3'd5, 32'h0040_0000, 32'h0, 0, 0, 0, 0, 0, 32'h0040_0000, 1'b0);
      run_instr(32'h1400_7FFF, 3'd2, 32'd1,        32'd2, 0, 0, 0, 0, 0, 32'h0042_0000, 1'b0);
      run_instr(32'h03E0_0008, 3'd5, 32'h0040_0020, 32'h0, 0, 0, 0, 0, 0, 32'h0040_0020, 1'b0);
      run_instr(32'h0C10_0010, 3'd4, 32'h0,        32'h0, 0, 0, 3, 0, 0, 32'h0040_0040, 1'b0);
      run_instr(32'h03E0_0008, 3'd5, 32'h0040_0102, 32'h0, 0, 0, 0, 0, 0, 32'h0040_0100, 1'b1);
      run_instr(32'h03E0_0008, 3'd5, 32'hFFFF_FFFC, 32'h0, 2, 0, 0, 1, 0, 32'hFFFF_FFFC, 1'b0);
      run_instr(32'h0000_0020, 3'd0, 32'h0,        32'h0, 0, 1, 0, 0, 1, 32'h0000_0000, 1'b0);
      run_instr(32'h0800_0010, 3'd3, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0000_0040, 1'b0);
      run_instr(32'h0000_0020, 3'd7, 32'h0,        32'h0, 0, 0, 0, 0, 0, 32'h0000_0044, 1'b0);
      reset_mid();
      run_instr(32'h0000_0020, 3'd0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 32'h0040_0004, 1'b0);

      wait_req(ok);
      @(negedge clk);
      #1;
      chk("fetchq_drained", 32'(fetchq.size()), 32'd0);
      chk("instrq_drained", 32'(instrq.size()), 32'd0);
      chk("resq_drained", 32'(resq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
